// File: rtl/pic24_pkg.sv
// pic24_pkg: shared widths, PC constants and the prefetch entry type for
// the PIC24 instruction fetch path.
package pic24_pkg;

    localparam int          PC_W    = 24;
    localparam int          INSTR_W = 24;
    localparam logic [23:0] PC_STEP = 24'd2;
    localparam logic [23:0] PC_MAX  = 24'h7FFFFE;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO of fetch_entry_t used as the prefetch
// buffer between the program ROM and decode.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         empty the FIFO (wins over push/pop)
//   push_i, data_i  write one entry
//   pop_i           remove the head entry (ignored when empty)
//   head_o          head entry, read straight from flops (zero when empty)
//   valid_o         FIFO non-empty
//   count_o         number of entries held
module fetch_fifo
    import pic24_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    // Shift-register organisation: entry 0 is always the head, so the
    // outputs come directly from flops and unused slots are kept at zero.
    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [CW-1:0]            count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        if (flush_i) begin
            mem_d   = '0;
            count_d = '0;
        end else begin
            if (pop_i && (count_q != '0)) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem_d[i] = mem_q[i+1];
                end
                mem_d[DEPTH-1] = '0;
                count_d        = count_q - CW'(1);
            end
            if (push_i) begin
                // Write slot is the occupancy after any same-cycle pop.
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == count_d) begin
                        mem_d[i] = data_i;
                    end
                end
                count_d = count_d + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[0];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PIC24 instruction fetch unit. Drives word addresses into the
// registered program ROM, tags returning words with their PC, buffers them
// in a prefetch FIFO and presents them to decode over valid/ready.
// Redirects flush everything and restart fetch at the new target.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   rom_addr_o        program-memory word address (current fetch PC)
//   rom_instr_i       ROM data, valid the cycle after the address
//   redirect_i        branch/jump: flush and restart at redirect_addr_i
//   redirect_addr_i   new PC (bits 23 and 0 ignored)
//   instr_valid_o     instr_o / instr_pc_o hold an instruction
//   instr_o           instruction word (0 when not valid)
//   instr_pc_o        PC of instr_o (0 when not valid)
//   instr_ready_i     decode accepts the presented word
//   pc_wrap_o         pulse when the fetch PC wraps past 0x7FFFFE
module instr_fetch
    import pic24_pkg::*;
#(
    parameter logic [23:0] RESET_VECTOR = 24'h000000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [23:0] rom_addr_o,
    input  logic [23:0] rom_instr_i,
    input  logic        redirect_i,
    input  logic [23:0] redirect_addr_i,
    output logic        instr_valid_o,
    output logic [23:0] instr_o,
    output logic [23:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        pc_wrap_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_v_q, inflight_v_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            fifo_valid;
    logic [CW-1:0]   count;
    logic            pop_req;
    logic            pop;
    logic            push;
    logic            issue;
    logic            at_max;
    logic [CW:0]     occ_next;

    logic            unused_addr_bits;
    assign unused_addr_bits = redirect_addr_i[23] ^ redirect_addr_i[0];

    assign pop_req = fifo_valid && instr_ready_i;
    assign pop     = pop_req && !redirect_i;
    assign push    = inflight_v_q && !redirect_i;

    // Occupancy the FIFO would reach if everything already committed lands;
    // counting the pop lets fetch resume in the same cycle ready returns.
    assign occ_next = {1'b0, count} + (CW+1)'(inflight_v_q) - (CW+1)'(pop_req);
    assign issue    = !redirect_i && (occ_next < (CW+1)'(FIFO_DEPTH));
    assign at_max   = (fetch_pc_q == PC_MAX);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_v_d  = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            fetch_pc_d = {1'b0, redirect_addr_i[22:1], 1'b0};
        end else if (issue) begin
            inflight_v_d  = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = at_max ? '0 : fetch_pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_VECTOR;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_data.instr = rom_instr_i;
    assign push_data.pc    = inflight_pc_q;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (redirect_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (head),
        .valid_o (fifo_valid),
        .count_o (count)
    );

    assign rom_addr_o    = fetch_pc_q;
    assign instr_valid_o = fifo_valid;
    assign instr_o       = fifo_valid ? head.instr : '0;
    assign instr_pc_o    = fifo_valid ? head.pc : '0;
    assign pc_wrap_o     = issue && at_max;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: instr_fetch paired with a registered program ROM whose
// word at address A is 0x00A000 + A. A reference model tracks the PC that
// decode must see next and checks every presented word against it.
module tb_instr_fetch;

    localparam logic [23:0] RV = 24'h000000;
    localparam int          D  = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [23:0] rom_addr_o;
    logic [23:0] rom_instr_i = '0;
    logic        redirect_i;
    logic [23:0] redirect_addr_i;
    logic        instr_valid_o;
    logic [23:0] instr_o;
    logic [23:0] instr_pc_o;
    logic        instr_ready_i;
    logic        pc_wrap_o;

    int          checks   = 0;
    int          failures = 0;
    int          wrap_seen = 0;
    logic [23:0] exp_pc;

    instr_fetch #(
        .RESET_VECTOR (RV),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rom_addr_o      (rom_addr_o),
        .rom_instr_i     (rom_instr_i),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_ready_i   (instr_ready_i),
        .pc_wrap_o       (pc_wrap_o)
    );

    always #5 clk_i = ~clk_i;

    // Registered program ROM.
    always @(posedge clk_i) rom_instr_i <= 24'h00A000 + rom_addr_o;

    always @(negedge clk_i) if (rst_ni && pc_wrap_o) wrap_seen++;

    function automatic logic [23:0] nxt(input logic [23:0] pc);
        return (pc + 24'd2) & 24'h7FFFFE;
    endfunction

    function automatic logic [23:0] word(input logic [23:0] pc);
        return 24'h00A000 + pc;
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Run n cycles with ready asserted ready_pct % of the time. Every
    // presented word must be the next expected one; with flow set, a
    // bubble is an error.
    task automatic stream(input int n, input int ready_pct, input bit flow);
        for (int c = 0; c < n; c++) begin
            instr_ready_i = (int'($urandom_range(99)) < ready_pct);
            if (instr_valid_o) begin
                check("pc_order", instr_pc_o, exp_pc);
                check("instr_word", instr_o, word(exp_pc));
                if (instr_ready_i) exp_pc = nxt(exp_pc);
            end else begin
                check("idle_zero", instr_o | instr_pc_o, 24'h0);
                if (flow) check("no_bubble", 24'(instr_valid_o), 24'd1);
            end
            step();
        end
    endtask

    // Redirect, then check flush and the two-edge target latency.
    task automatic do_redirect(input logic [23:0] addr, input logic rdy);
        logic [23:0] tgt;
        tgt             = addr & 24'h7FFFFE;
        redirect_i      = 1'b1;
        redirect_addr_i = addr;
        instr_ready_i   = rdy;
        step();
        redirect_i    = 1'b0;
        instr_ready_i = 1'b0;
        check("redir_addr", rom_addr_o, tgt);
        check("redir_flush", 24'(instr_valid_o), 24'd0);
        step();
        check("redir_wait", 24'(instr_valid_o), 24'd0);
        step();
        check("redir_valid", 24'(instr_valid_o), 24'd1);
        check("redir_pc", instr_pc_o, tgt);
        check("redir_word", instr_o, word(tgt));
        exp_pc = tgt;
    endtask

    task automatic startup();
        step();
        check("e0_valid", 24'(instr_valid_o), 24'd0);
        check("e0_addr", rom_addr_o, nxt(RV));
        step();
        check("e1_valid", 24'(instr_valid_o), 24'd1);
        check("e1_pc", instr_pc_o, RV);
        check("e1_word", instr_o, word(RV));
        exp_pc = RV;
    endtask

    initial begin
        int wrap_base;
        rst_ni          = 1'b0;
        redirect_i      = 1'b0;
        redirect_addr_i = '0;
        instr_ready_i   = 1'b0;
        repeat (3) step();
        check("rst_addr", rom_addr_o, RV);
        check("rst_valid", 24'(instr_valid_o), 24'd0);
        check("rst_instr", instr_o, 24'h0);
        check("rst_pc", instr_pc_o, 24'h0);
        check("rst_wrap", 24'(pc_wrap_o), 24'd0);

        // Release reset between edges; ready held high.
        rst_ni        = 1'b1;
        instr_ready_i = 1'b1;
        startup();
        stream(20, 100, 1'b1);

        // Backpressure: exactly D words held, fetch frozen.
        instr_ready_i = 1'b0;
        repeat (10) step();
        check("bp_addr", rom_addr_o, nxt(nxt(exp_pc)));
        check("bp_valid", 24'(instr_valid_o), 24'd1);
        check("bp_head", instr_pc_o, exp_pc);
        stream(20, 100, 1'b1);

        // Redirect with a full pipeline (word buffered plus one in flight).
        do_redirect(24'h001235, 1'b0);
        stream(15, 100, 1'b1);

        // Redirect in a cycle that also pops and pushes.
        do_redirect(24'h000100, 1'b1);
        stream(10, 100, 1'b1);

        // Wrap past 0x7FFFFE.
        wrap_base = wrap_seen;
        do_redirect(24'h7FFFFC, 1'b1);
        stream(8, 100, 1'b1);
        check("wrap_count", 24'(wrap_seen - wrap_base), 24'd1);

        // Random ready with occasional random redirects.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(19) == 0)
                do_redirect($urandom(), 1'($urandom_range(1)));
            else
                stream(1, 70, 1'b0);
        end

        // Asynchronous reset mid-stream.
        stream(5, 100, 1'b1);
        rst_ni = 1'b0;
        #1;
        check("mrst_addr", rom_addr_o, RV);
        check("mrst_valid", 24'(instr_valid_o), 24'd0);
        check("mrst_instr", instr_o, 24'h0);
        check("mrst_pc", instr_pc_o, 24'h0);
        check("mrst_wrap", 24'(pc_wrap_o), 24'd0);
        step();
        rst_ni        = 1'b1;
        instr_ready_i = 1'b1;
        startup();
        stream(10, 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
